img_descpt_feeder: RTL and testbench



---
 rtl/img_descpt_feeder_pkg.sv | 25 ++
 rtl/img_descpt_feeder_rcd_pack4.sv | 40 ++++
 rtl/img_descpt_feeder.sv | 152 +++++++++++++++
 tb/tb_img_descpt_feeder.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/img_descpt_feeder_pkg.sv
// Shared widths, field split and state encoding for the image descriptor feeder.
package img_descpt_feeder_pkg;

   localparam int RCD_W   = 403;
   localparam int KPT_W   = 11;
   localparam int GRP_W   = KPT_W - 2;
   localparam int SLOTS   = 4;
   localparam int DESC_W  = 384;
   localparam int HDR_LSB = DESC_W;
   localparam int HDR_W   = RCD_W - DESC_W;

   typedef enum logic [2:0] {
      IDLE,
      WAIT_REQ,
      FETCH,
      DRAIN,
      DELIVER
   } feeder_state_t;

   // Trailing kpt_num%4 keypoints never form a group, matching the match engine.
   function automatic logic [GRP_W-1:0] grp_count(input logic [KPT_W-1:0] kpt);
      return kpt[KPT_W-1:2];
   endfunction

endpackage

// File: rtl/img_descpt_feeder_rcd_pack4.sv
// Four-slot shadow register file with a parallel load into the output group registers.
module rcd_pack4
   import img_descpt_feeder_pkg::*;
(
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          wr_en_i,
   input  logic [1:0]                    wr_slot_i,
   input  logic [RCD_W-1:0]              wr_data_i,
   input  logic                          load_i,
   output logic [SLOTS-1:0][RCD_W-1:0]   rcd_o
);

   logic [SLOTS-1:0][RCD_W-1:0] shadow_q;
   logic [SLOTS-1:0][RCD_W-1:0] shadow_d;
   logic [SLOTS-1:0][RCD_W-1:0] rcd_q;

   // The load sees a same-cycle slot write, so the last word goes straight to the outputs.
   always_comb begin
      shadow_d = shadow_q;
      if (wr_en_i) begin
         shadow_d[wr_slot_i] = wr_data_i;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shadow_q <= '0;
         rcd_q    <= '0;
      end else begin
         shadow_q <= shadow_d;
         if (load_i) begin
            rcd_q <= shadow_d;
         end
      end
   end

   assign rcd_o = rcd_q;

endmodule

// File: rtl/img_descpt_feeder.sv
// Fetches four consecutive image keypoint words per request and hands them to the match engine
// as one group, tracking how many groups remain for the current kpt_num.
module img_descpt_feeder
   import img_descpt_feeder_pkg::*;
(
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic [KPT_W-1:0]   kpt_num,
   input  logic               descriptor_request,
   output logic               descriptor_valid,
   output logic [RCD_W-1:0]   image_R_C_D_0,
   output logic [RCD_W-1:0]   image_R_C_D_1,
   output logic [RCD_W-1:0]   image_R_C_D_2,
   output logic [RCD_W-1:0]   image_R_C_D_3,
   output logic [KPT_W-1:0]   img_addr,
   output logic               img_re,
   input  logic [RCD_W-1:0]   img_dout,
   output logic [GRP_W-1:0]   group_idx,
   output logic               busy,
   output logic               err
);

   feeder_state_t               state_q, state_d;
   logic [1:0]                  slot_q, slot_d;
   logic [GRP_W-1:0]            next_grp_q, next_grp_d;
   logic [GRP_W-1:0]            grp_total_q, grp_total_d;
   logic [GRP_W-1:0]            group_idx_q, group_idx_d;
   logic                        busy_q, busy_d;
   logic                        err_q, err_d;
   logic                        exhausted_q, exhausted_d;
   logic                        valid_q, valid_d;
   logic                        cap_en_q;
   logic [1:0]                  cap_slot_q;
   logic                        load;
   logic [SLOTS-1:0][RCD_W-1:0] rcd;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         slot_q      <= '0;
         next_grp_q  <= '0;
         grp_total_q <= '0;
         group_idx_q <= '0;
         busy_q      <= 1'b0;
         err_q       <= 1'b0;
         exhausted_q <= 1'b0;
         valid_q     <= 1'b0;
         cap_en_q    <= 1'b0;
         cap_slot_q  <= '0;
      end else begin
         state_q     <= state_d;
         slot_q      <= slot_d;
         next_grp_q  <= next_grp_d;
         grp_total_q <= grp_total_d;
         group_idx_q <= group_idx_d;
         busy_q      <= busy_d;
         err_q       <= err_d;
         exhausted_q <= exhausted_d;
         valid_q     <= valid_d;
         cap_en_q    <= img_re;
         cap_slot_q  <= slot_q;
      end
   end

   // The group registers, group_idx and valid all move on the DRAIN->DELIVER edge.
   always_comb begin
      state_d     = state_q;
      slot_d      = slot_q;
      next_grp_d  = next_grp_q;
      grp_total_d = grp_total_q;
      group_idx_d = group_idx_q;
      busy_d      = busy_q;
      err_d       = err_q;
      exhausted_d = exhausted_q;
      valid_d     = 1'b0;
      load        = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (start) begin
               grp_total_d = grp_count(kpt_num);
               next_grp_d  = '0;
               err_d       = 1'b0;
               exhausted_d = 1'b0;
               if (grp_count(kpt_num) == '0) begin
                  err_d = 1'b1;
               end else begin
                  busy_d  = 1'b1;
                  state_d = WAIT_REQ;
               end
            end else if (descriptor_request && exhausted_q) begin
               err_d = 1'b1;
            end
         end
         WAIT_REQ: begin
            if (descriptor_request) begin
               slot_d  = '0;
               state_d = FETCH;
            end
         end
         FETCH: begin
            slot_d = slot_q + 2'd1;
            if (slot_q == 2'd3) begin
               state_d = DRAIN;
            end
         end
         DRAIN: begin
            load        = 1'b1;
            valid_d     = 1'b1;
            group_idx_d = next_grp_q;
            next_grp_d  = next_grp_q + 1'b1;
            state_d     = DELIVER;
         end
         DELIVER: begin
            if (next_grp_q == grp_total_q) begin
               busy_d      = 1'b0;
               exhausted_d = 1'b1;
               state_d     = IDLE;
            end else begin
               state_d = WAIT_REQ;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign img_re   = (state_q == FETCH);
   assign img_addr = {next_grp_q, slot_q};

   rcd_pack4 u_pack (
      .clk       (clk),
      .rst_n     (rst_n),
      .wr_en_i   (cap_en_q),
      .wr_slot_i (cap_slot_q),
      .wr_data_i (img_dout),
      .load_i    (load),
      .rcd_o     (rcd)
   );

   assign image_R_C_D_0    = rcd[0];
   assign image_R_C_D_1    = rcd[1];
   assign image_R_C_D_2    = rcd[2];
   assign image_R_C_D_3    = rcd[3];
   assign descriptor_valid = valid_q;
   assign group_idx        = group_idx_q;
   assign busy             = busy_q;
   assign err              = err_q;

endmodule

// File: tb/tb_img_descpt_feeder.sv
// Scoreboard bench for img_descpt_feeder: SRAM word i holds value i, and each request pushes
// the group it should deliver.
module tb_img_descpt_feeder;
   import img_descpt_feeder_pkg::*;

   logic               clk = 1'b0;
   logic               rst_n;
   logic               start;
   logic [KPT_W-1:0]   kpt_num;
   logic               descriptor_request;
   logic               descriptor_valid;
   logic [RCD_W-1:0]   image_R_C_D_0;
   logic [RCD_W-1:0]   image_R_C_D_1;
   logic [RCD_W-1:0]   image_R_C_D_2;
   logic [RCD_W-1:0]   image_R_C_D_3;
   logic [KPT_W-1:0]   img_addr;
   logic               img_re;
   logic [RCD_W-1:0]   img_dout = '0;
   logic [GRP_W-1:0]   group_idx;
   logic               busy;
   logic               err;

   typedef struct {
      logic [SLOTS-1:0][RCD_W-1:0] w;
      logic [GRP_W-1:0]            g;
   } exp_t;

   exp_t expQ[$];
   int   total = 0;
   int   bad = 0;
   int   reCount = 0;
   int   maxAddr = 0;

   img_descpt_feeder dut (
      .clk                (clk),
      .rst_n              (rst_n),
      .start              (start),
      .kpt_num            (kpt_num),
      .descriptor_request (descriptor_request),
      .descriptor_valid   (descriptor_valid),
      .image_R_C_D_0      (image_R_C_D_0),
      .image_R_C_D_1      (image_R_C_D_1),
      .image_R_C_D_2      (image_R_C_D_2),
      .image_R_C_D_3      (image_R_C_D_3),
      .img_addr           (img_addr),
      .img_re             (img_re),
      .img_dout           (img_dout),
      .group_idx          (group_idx),
      .busy               (busy),
      .err                (err)
   );

   always #5 clk = ~clk;

   // Keypoint SRAM model with one-cycle read latency, plus read activity bookkeeping.
   always @(posedge clk) begin
      if (img_re) begin
         img_dout <= RCD_W'(img_addr);
         reCount  = reCount + 1;
         if (int'(img_addr) > maxAddr) maxAddr = int'(img_addr);
      end
   end

   task automatic checkOutput(input string tag, input logic [511:0] obs, input logic [511:0] exp);
      total = total + 1;
      if (obs !== exp) begin
         bad = bad + 1;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   always @(negedge clk) begin
      if (rst_n === 1'b1 && descriptor_valid === 1'b1) begin
         if (expQ.size() == 0) begin
            checkOutput("unexpected_valid", 1, 0);
         end else begin
            exp_t e;
            e = expQ.pop_front();
            checkOutput("rcd0", image_R_C_D_0, e.w[0]);
            checkOutput("rcd1", image_R_C_D_1, e.w[1]);
            checkOutput("rcd2", image_R_C_D_2, e.w[2]);
            checkOutput("rcd3", image_R_C_D_3, e.w[3]);
            checkOutput("group_idx", group_idx, e.g);
         end
      end
   end

   task automatic clearMon();
      reCount = 0;
      maxAddr = 0;
   endtask

   task automatic applyStimulus(input int kpt);
      kpt_num = KPT_W'(kpt);
      start   = 1'b1;
      @(negedge clk);
      start   = 1'b0;
   endtask

   // Consumer model: raise request, wait for valid, keep request up through DELIVER, then drop it.
   task automatic requestGroup(input int g, input bit last);
      exp_t e;
      int   n;
      bit   seen;
      for (int k = 0; k < SLOTS; k++) e.w[k] = RCD_W'(4 * g + k);
      e.g = GRP_W'(g);
      expQ.push_back(e);
      descriptor_request = 1'b1;
      n    = 0;
      seen = 1'b0;
      while (!seen && n < 20) begin
         @(posedge clk);
         n = n + 1;
         @(negedge clk);
         seen = descriptor_valid;
      end
      if (!seen) begin
         checkOutput("valid_timeout", 0, 1);
      end else begin
         checkOutput("latency", n, 6);
         checkOutput("busy_at_valid", busy, 1);
      end
      @(negedge clk);
      descriptor_request = 1'b0;
      checkOutput("valid_width", descriptor_valid, 0);
      checkOutput("busy_after", busy, last ? 1'b0 : 1'b1);
   endtask

   initial begin
      rst_n = 1'b0;
      start = 1'b0;
      kpt_num = '0;
      descriptor_request = 1'b0;
      repeat (3) @(negedge clk);
      checkOutput("rst_valid", descriptor_valid, 0);
      checkOutput("rst_rcd0", image_R_C_D_0, 0);
      checkOutput("rst_rcd3", image_R_C_D_3, 0);
      checkOutput("rst_addr", img_addr, 0);
      checkOutput("rst_re", img_re, 0);
      checkOutput("rst_gidx", group_idx, 0);
      checkOutput("rst_busy", busy, 0);
      checkOutput("rst_err", err, 0);
      rst_n = 1'b1;
      @(negedge clk);

      // Two groups from kpt_num=8.
      clearMon();
      applyStimulus(8);
      checkOutput("k8_busy", busy, 1);
      checkOutput("k8_err", err, 0);
      requestGroup(0, 1'b0);
      repeat (3) @(negedge clk);
      checkOutput("no_refetch", reCount, 4);
      checkOutput("hold_rcd1", image_R_C_D_1, 1);
      requestGroup(1, 1'b1);
      checkOutput("k8_reads", reCount, 8);
      checkOutput("k8_maxaddr", maxAddr, 7);
      checkOutput("k8_err_end", err, 0);

      // Request after exhaustion.
      descriptor_request = 1'b1;
      repeat (3) @(negedge clk);
      descriptor_request = 1'b0;
      checkOutput("exh_err", err, 1);
      checkOutput("exh_reads", reCount, 8);
      checkOutput("exh_rcd3", image_R_C_D_3, 7);
      checkOutput("exh_gidx", group_idx, 1);

      // kpt_num=7 yields only one group.
      clearMon();
      applyStimulus(7);
      checkOutput("k7_err_clr", err, 0);
      requestGroup(0, 1'b1);
      repeat (2) @(negedge clk);
      checkOutput("k7_reads", reCount, 4);
      checkOutput("k7_maxaddr", maxAddr, 3);

      // kpt_num=3 yields no group.
      clearMon();
      applyStimulus(3);
      checkOutput("k3_err", err, 1);
      checkOutput("k3_busy", busy, 0);
      repeat (4) @(negedge clk);
      checkOutput("k3_reads", reCount, 0);

      // Reset on the second FETCH cycle, then a clean restart.
      applyStimulus(4);
      descriptor_request = 1'b1;
      @(posedge clk);
      @(posedge clk);
      #1;
      checkOutput("abort_fetching", img_re, 1);
      rst_n = 1'b0;
      #1;
      checkOutput("abort_re", img_re, 0);
      checkOutput("abort_valid", descriptor_valid, 0);
      checkOutput("abort_rcd0", image_R_C_D_0, 0);
      checkOutput("abort_rcd2", image_R_C_D_2, 0);
      checkOutput("abort_busy", busy, 0);
      descriptor_request = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      clearMon();
      applyStimulus(4);
      requestGroup(0, 1'b1);
      checkOutput("restart_reads", reCount, 4);
      repeat (3) @(negedge clk);
      checkOutput("queue_empty", expQ.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
